// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit arbiter and its sub-blocks.
//   uart_arb_state_t   : 3-bit encoded arbiter FSM state
//   UART_ARB_WD_CYCLES : default cycles allowed between DATA_VALID and Busy
//   next_ptr()         : modulo-nreq increment for the round-robin pointer
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_LAUNCH    = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_RELEASE   = 3'd4
  } uart_arb_state_t;

  localparam int UART_ARB_WD_CYCLES = 4;

  // Index of the source after idx, wrapping back to 0 past the last one.
  function automatic int next_ptr(input int idx, input int nreq);
    return (idx + 1 >= nreq) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin priority encoder. Searches req upward starting
// at ptr, wrapping modulo NREQ, and reports the first asserted request.
// Ports:
//   req : per-source request vector
//   ptr : index the search starts from
//   gnt : one-hot winner (all zero when no request is asserted)
//   idx : binary index of the winner (zero when no request is asserted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx
);

  int              cand;
  logic [IDXW-1:0] cand_idx;
  logic            found;

  // Walk the candidates in rotated order; the first hit wins and the
  // found flag masks every later candidate.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDXW'(cand);
      if (!found && req[cand_idx]) begin
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NREQ byte sources in round-robin order.
// The winner's byte and parity settings are latched into holding registers,
// DATA_VALID is pulsed for one cycle, the transmitter's Busy is followed
// through the frame, and a one-cycle DONE is returned to the source. A
// watchdog releases the grant (with ERR) if Busy never rises after launch.
// Ports:
//   CLK, RST           : clock, asynchronous active-low reset
//   REQ                : per-source request, held until that source's DONE
//   REQ_DATA           : packed bytes, source i at [i*WIDTH +: WIDTH]
//   REQ_PAR_EN/TYP     : per-source parity enable / type (1 = odd)
//   Busy               : transmitter busy flag
//   GNT                : one-hot grant, held for the whole transaction
//   DONE               : one-cycle completion pulse to the granted source
//   ERR                : one-cycle pulse when the watchdog expires
//   P_DATA, DATA_VALID,
//   PAR_EN, PAR_TYP    : transmitter launch interface
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int WD_CYCLES = UART_ARB_WD_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] REQ_DATA,
  input  logic [NREQ-1:0]       REQ_PAR_EN,
  input  logic [NREQ-1:0]       REQ_PAR_TYP,
  input  logic                  Busy,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic                  ERR,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_EN,
  output logic                  PAR_TYP
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW  = $clog2(WD_CYCLES + 1);

  uart_arb_state_t state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] gnt_idx;
  logic [IDXW-1:0] arb_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [NREQ-1:0] gnt_q;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] p_data_q;
  logic            par_en_q;
  logic            par_typ_q;
  logic            err_q;
  logic [WDW-1:0]  wd_cnt;
  logic            arb_go;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arbiter (
    .req (REQ),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Byte lane of the current arbitration winner.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDXW'(i)) sel_data = REQ_DATA[i*WIDTH +: WIDTH];
    end
  end

  // A launch is only considered while the transmitter is idle, which also
  // keeps us from launching into a frame that survived a reset.
  assign arb_go = (|REQ) && !Busy;

  // Transaction FSM. The holding registers are written only on a win, so
  // the transmitter sees stable data and parity settings for the whole
  // frame even if the source changes its inputs or drops REQ early.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_q     <= '0;
      p_data_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      err_q     <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (arb_go) begin
            gnt_q     <= arb_gnt;
            gnt_idx   <= arb_idx;
            p_data_q  <= sel_data;
            par_en_q  <= REQ_PAR_EN[arb_idx];
            par_typ_q <= REQ_PAR_TYP[arb_idx];
            state     <= ARB_LAUNCH;
          end
        end
        ARB_LAUNCH: begin
          wd_cnt <= '0;
          state  <= ARB_WAIT_BUSY;
        end
        ARB_WAIT_BUSY: begin
          if (Busy) begin
            state <= ARB_WAIT_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == WDW'(WD_CYCLES - 1)) begin
              err_q <= 1'b1;
              state <= ARB_RELEASE;
            end
          end
        end
        ARB_WAIT_DONE: begin
          if (!Busy) state <= ARB_RELEASE;
        end
        ARB_RELEASE: begin
          gnt_q <= '0;
          ptr   <= IDXW'(next_ptr(int'(gnt_idx), NREQ));
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign GNT        = gnt_q;
  assign DONE       = (state == ARB_RELEASE) ? gnt_q : '0;
  assign ERR        = err_q;
  assign P_DATA     = p_data_q;
  assign DATA_VALID = (state == ARB_LAUNCH);
  assign PAR_EN     = par_en_q;
  assign PAR_TYP    = par_typ_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter. A small behavioural transmitter raises
// Busy one cycle after DATA_VALID and holds it for frame_len cycles; it can
// be switched off so the bench drives Busy directly.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int WD    = 4;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NREQ-1:0]       REQ;
  logic [NREQ*WIDTH-1:0] REQ_DATA;
  logic [NREQ-1:0]       REQ_PAR_EN;
  logic [NREQ-1:0]       REQ_PAR_TYP;
  logic                  Busy;
  logic [NREQ-1:0]       GNT;
  logic [NREQ-1:0]       DONE;
  logic                  ERR;
  logic [WIDTH-1:0]      P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural transmitter
  logic       tx_auto    = 1'b1;
  logic       busy_force = 1'b0;
  logic       busy_model = 1'b0;
  int         busy_cnt   = 0;
  int         frame_len  = 6;
  logic [7:0] tx_byte    = 8'h00;
  logic       tx_par_en  = 1'b0;
  logic       tx_par_typ = 1'b0;
  int         dv_while_busy = 0;

  assign Busy = tx_auto ? busy_model : busy_force;

  uart_tx_arbiter #(
    .WIDTH     (WIDTH),
    .NREQ      (NREQ),
    .WD_CYCLES (WD)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ         (REQ),
    .REQ_DATA    (REQ_DATA),
    .REQ_PAR_EN  (REQ_PAR_EN),
    .REQ_PAR_TYP (REQ_PAR_TYP),
    .Busy        (Busy),
    .GNT         (GNT),
    .DONE        (DONE),
    .ERR         (ERR),
    .P_DATA      (P_DATA),
    .DATA_VALID  (DATA_VALID),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP)
  );

  always #5 CLK = ~CLK;

  // Transmitter model: latch the launch and run a fixed-length frame.
  always @(posedge CLK) begin
    if (tx_auto && DATA_VALID && !busy_model) begin
      busy_model <= 1'b1;
      busy_cnt   <= frame_len - 1;
      tx_byte    <= P_DATA;
      tx_par_en  <= PAR_EN;
      tx_par_typ <= PAR_TYP;
    end else if (busy_model) begin
      if (busy_cnt == 0) busy_model <= 1'b0;
      else               busy_cnt   <= busy_cnt - 1;
    end
  end

  // Launching into a running frame is a protocol violation.
  always @(posedge CLK) begin
    if (DATA_VALID === 1'b1 && Busy === 1'b1) dv_while_busy <= dv_while_busy + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_for_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (DATA_VALID === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Waits for DONE; reports how often P_DATA moved and how many cycles
  // separated the Busy fall from DONE.
  task automatic wait_for_done(output bit ok, output int bad_hold, output int lag);
    logic [7:0] held;
    logic       prev_busy;
    int         fall_t;
    held = P_DATA; prev_busy = Busy; fall_t = -1;
    ok = 1'b0; bad_hold = 0; lag = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (DONE !== '0) begin
        ok  = 1'b1;
        lag = (fall_t >= 0) ? i - fall_t : -1;
        return;
      end
      if (P_DATA !== held) bad_hold++;
      if (prev_busy && !Busy) fall_t = i;
      prev_busy = Busy;
    end
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b0; REQ = '0; REQ_DATA = '0; REQ_PAR_EN = '0; REQ_PAR_TYP = '0;
    #3;
    tests_run++;
    if ({GNT, DONE, ERR, DATA_VALID, PAR_EN, PAR_TYP} !== '0 || P_DATA !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got gnt=%b done=%b err=%b dv=%b pe=%b pt=%b pd=%h, required all 0",
               GNT, DONE, ERR, DATA_VALID, PAR_EN, PAR_TYP, P_DATA);
    end
    REQ = 4'b0101;
    tick(); tick();
    tests_run++;
    if (GNT !== '0 || DATA_VALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_holds: got gnt=%b dv=%b, required 0000/0", GNT, DATA_VALID);
    end
    REQ = '0;
    RST = 1'b1;
    tick();
  endtask

  task automatic test_single_request();
    bit ok; int bad; int lag;
    frame_len = 6;
    REQ = 4'b0010; REQ_DATA = 32'h0000_A500; REQ_PAR_EN = 4'b0010; REQ_PAR_TYP = 4'b0000;
    tick();
    tests_run++;
    if (GNT !== 4'b0010 || DATA_VALID !== 1'b1 || P_DATA !== 8'hA5 || PAR_EN !== 1'b1 || PAR_TYP !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_launch: got gnt=%b dv=%b pd=%h pe=%b pt=%b, required 0010/1/a5/1/0",
               GNT, DATA_VALID, P_DATA, PAR_EN, PAR_TYP);
    end
    wait_for_done(ok, bad, lag);
    tests_run++;
    if (!ok || DONE !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL single_done: got ok=%0d done=%b, required 1/0010", ok, DONE);
    end
    tests_run++;
    if (lag !== 1) begin
      tests_failed++;
      $display("[TB] FAIL single_done_lag: got %0d cycles after Busy fall, required 1", lag);
    end
    tests_run++;
    if (bad !== 0 || P_DATA !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL single_hold: got %0d changes pd=%h, required 0 changes pd=a5", bad, P_DATA);
    end
    tests_run++;
    if (tx_byte !== 8'hA5 || tx_par_en !== 1'b1 || tx_par_typ !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_tx_frame: got byte=%h pe=%b pt=%b, required a5/1/0", tx_byte, tx_par_en, tx_par_typ);
    end
    REQ = '0;
    tick();
    tests_run++;
    if (DONE !== '0 || GNT !== '0) begin
      tests_failed++;
      $display("[TB] FAIL single_release: got done=%b gnt=%b, required 0000/0000", DONE, GNT);
    end
  endtask

  task automatic test_contention();
    bit ok; int bad; int lag;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    pulse_reset();
    REQ = 4'b1111; REQ_DATA = 32'h1312_1110; REQ_PAR_EN = 4'b0000; REQ_PAR_TYP = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << exp_order[k];
      wait_for_valid(ok);
      tests_run++;
      if (!ok || GNT !== exp_g || P_DATA !== 8'h10 + 8'(exp_order[k])) begin
        tests_failed++;
        $display("[TB] FAIL contention_grant%0d: got ok=%0d gnt=%b pd=%h, required gnt=%b pd=%h",
                 k, ok, GNT, P_DATA, exp_g, 8'h10 + 8'(exp_order[k]));
      end
      wait_for_done(ok, bad, lag);
      tests_run++;
      if (!ok || DONE !== exp_g || bad !== 0) begin
        tests_failed++;
        $display("[TB] FAIL contention_done%0d: got ok=%0d done=%b holdchg=%0d, required done=%b holdchg=0",
                 k, ok, DONE, bad, exp_g);
      end
      if (k == 4) REQ = '0;
      tick();
      tests_run++;
      if (DONE !== '0) begin
        tests_failed++;
        $display("[TB] FAIL contention_done_once%0d: got done=%b, required 0000", k, DONE);
      end
    end
  endtask

  task automatic test_pointer_wrap();
    bit ok; int bad; int lag;
    REQ = 4'b1000; REQ_DATA = 32'hC300_000F;
    wait_for_valid(ok);
    tests_run++;
    if (!ok || GNT !== 4'b1000 || P_DATA !== 8'hC3) begin
      tests_failed++;
      $display("[TB] FAIL wrap_src3: got ok=%0d gnt=%b pd=%h, required 1000/c3", ok, GNT, P_DATA);
    end
    wait_for_done(ok, bad, lag);
    REQ = 4'b1001;
    wait_for_valid(ok);
    tests_run++;
    if (!ok || GNT !== 4'b0001 || P_DATA !== 8'h0F) begin
      tests_failed++;
      $display("[TB] FAIL wrap_src0: got ok=%0d gnt=%b pd=%h, required 0001/0f", ok, GNT, P_DATA);
    end
    wait_for_done(ok, bad, lag);
    REQ = 4'b1000;
    wait_for_valid(ok);
    tests_run++;
    if (!ok || GNT !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL wrap_src3_again: got ok=%0d gnt=%b, required 1000", ok, GNT);
    end
    wait_for_done(ok, bad, lag);
    REQ = '0;
    tick();
  endtask

  task automatic test_watchdog();
    bit ok;
    int early;
    tx_auto = 1'b0; busy_force = 1'b0;
    REQ = 4'b0001; REQ_DATA = 32'h0000_003C;
    wait_for_valid(ok);
    tests_run++;
    if (!ok || GNT !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL wd_launch: got ok=%0d gnt=%b, required 0001", ok, GNT);
    end
    early = 0;
    for (int i = 0; i < WD; i++) begin
      tick();
      if (ERR !== 1'b0 || DONE !== '0) early++;
    end
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("[TB] FAIL wd_early: got %0d early err/done cycles, required 0", early);
    end
    tick();
    tests_run++;
    if (ERR !== 1'b1 || DONE !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL wd_expire: got err=%b done=%b, required 1/0001", ERR, DONE);
    end
    REQ = '0;
    tick();
    tests_run++;
    if (ERR !== 1'b0 || DONE !== '0 || GNT !== '0) begin
      tests_failed++;
      $display("[TB] FAIL wd_pulse: got err=%b done=%b gnt=%b, required 0/0000/0000", ERR, DONE, GNT);
    end
    tx_auto = 1'b1;
    tick();
  endtask

  task automatic test_reset_midframe();
    bit ok; int bad; int lag;
    int early;
    frame_len = 12;
    REQ = 4'b0100; REQ_DATA = 32'h0077_0000; REQ_PAR_EN = 4'b0100; REQ_PAR_TYP = 4'b0100;
    wait_for_valid(ok);
    tick(); tick(); tick();
    RST = 1'b0;
    #1;
    tests_run++;
    if ({GNT, DONE, ERR, DATA_VALID, PAR_EN, PAR_TYP} !== '0 || P_DATA !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset: got gnt=%b done=%b err=%b dv=%b pe=%b pt=%b pd=%h, required all 0",
               GNT, DONE, ERR, DATA_VALID, PAR_EN, PAR_TYP, P_DATA);
    end
    #1;
    RST = 1'b1;
    early = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (DATA_VALID === 1'b1) early++;
      if (Busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok || early !== 0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_no_launch: got busyend=%0d launches=%0d, required 1/0", ok, early);
    end
    wait_for_valid(ok);
    tests_run++;
    if (!ok || GNT !== 4'b0100 || P_DATA !== 8'h77) begin
      tests_failed++;
      $display("[TB] FAIL midframe_relaunch: got ok=%0d gnt=%b pd=%h, required 0100/77", ok, GNT, P_DATA);
    end
    wait_for_done(ok, bad, lag);
    REQ = '0;
    tick();
  endtask

  task automatic test_data_change();
    bit ok; int bad; int lag;
    frame_len = 6;
    REQ = 4'b0010; REQ_DATA = 32'h0000_5A00; REQ_PAR_EN = 4'b0010; REQ_PAR_TYP = 4'b0010;
    wait_for_valid(ok);
    tests_run++;
    if (!ok || GNT !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL change_grant: got ok=%0d gnt=%b, required 0010", ok, GNT);
    end
    REQ_DATA = 32'h0000_FF00; REQ_PAR_EN = '0; REQ_PAR_TYP = '0;
    wait_for_done(ok, bad, lag);
    tests_run++;
    if (!ok || bad !== 0 || P_DATA !== 8'h5A || PAR_EN !== 1'b1 || PAR_TYP !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL change_hold: got ok=%0d chg=%0d pd=%h pe=%b pt=%b, required 1/0/5a/1/1",
               ok, bad, P_DATA, PAR_EN, PAR_TYP);
    end
    tests_run++;
    if (tx_byte !== 8'h5A || tx_par_typ !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL change_tx_frame: got byte=%h pt=%b, required 5a/1", tx_byte, tx_par_typ);
    end
    REQ = '0;
    tick();
  endtask

  task automatic test_protocol();
    tests_run++;
    if (dv_while_busy !== 0) begin
      tests_failed++;
      $display("[TB] FAIL dv_while_busy: got %0d launches during Busy, required 0", dv_while_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_contention();
    test_pointer_wrap();
    test_watchdog();
    test_reset_midframe();
    test_data_change();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
